// File: rtl/rom_port_arbiter_pkg.sv
// Shared definitions for the ROM read-port arbiter: load encodings, requester IDs and
// default geometry.
package rom_port_arbiter_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

    localparam int unsigned DEFAULT_DEPTH = 65;
    localparam int unsigned DEFAULT_IDX_W = 7;

endpackage

// File: rtl/rom_port_arbiter_load_align.sv
// Combinational load extractor: selects byte/halfword/word from a 32-bit word and
// sign/zero-extends it. Misaligned accesses return 0 with misalign set.
module rom_port_arbiter_load_align
    import rom_port_arbiter_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        misalign
);

    logic [15:0] shifted;

    assign shifted = 16'(word >> {addr, 3'b000});

    always_comb begin
        data     = '0;
        misalign = 1'b0;
        case (funct3)
            LB:  data = {{24{shifted[7]}}, shifted[7:0]};
            LBU: data = {24'b0, shifted[7:0]};
            LH, LHU: begin
                if (addr[0]) begin
                    misalign = 1'b1;
                end else begin
                    data = {{16{(funct3 == LH) && shifted[15]}}, shifted[15:0]};
                end
            end
            // lw and the reserved encodings
            default: begin
                if (addr != 2'b00) begin
                    misalign = 1'b1;
                end else begin
                    data = word;
                end
            end
        endcase
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the instruction ROM read port between fetch (IF) and loads (D), one grant per
// cycle, data returned one cycle later. Define ARB_RR_EN for round-robin arbitration.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter int unsigned IDX_W    = DEFAULT_IDX_W,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [31:0]      if_rdata,
    input  logic             d_req,
    input  logic [31:0]      d_addr,
    input  logic [2:0]       d_funct3,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [31:0]      d_rdata,
    output logic             d_misalign,
    output logic [IDX_W-1:0] mem_idx,
    input  logic [31:0]      mem_rdata
);

    logic             any_gnt;
    logic [IDX_W+1:0] gnt_addr;
    logic             oob;

    logic        valid_q;
    req_id_e     owner_q;
    logic [31:0] word_q;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;

    logic [31:0] al_data;
    logic        al_misalign;

`ifdef ARB_RR_EN
    req_id_e last_q, last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= REQ_IF;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            if (if_req && d_req) begin
                if (last_q == REQ_D) begin
                    if_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (if_gnt) begin
            last_d = REQ_IF;
        end else if (d_gnt) begin
            last_d = REQ_D;
        end
    end
`else
    localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              starved;

    assign starved = (wait_q == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    // D has priority unless IF has been denied MAX_WAIT cycles in a row
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            if (if_req && starved) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (!if_req || if_gnt) begin
            wait_d = '0;
        end else if (!starved) begin
            wait_d = wait_q + 1'b1;
        end
    end
`endif

    assign any_gnt  = if_gnt | d_gnt;
    assign gnt_addr = d_gnt ? d_addr[IDX_W+1:0] : if_addr[IDX_W+1:0];
    assign mem_idx  = any_gnt ? gnt_addr[IDX_W+1:2] : '0;
    assign oob      = (32'(mem_idx) >= DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            owner_q  <= REQ_IF;
            word_q   <= '0;
            off_q    <= '0;
            funct3_q <= '0;
        end else begin
            valid_q <= any_gnt;
            if (any_gnt) begin
                owner_q  <= d_gnt ? REQ_D : REQ_IF;
                word_q   <= oob ? 32'b0 : mem_rdata;
                off_q    <= gnt_addr[1:0];
                funct3_q <= d_funct3;
            end
        end
    end

    rom_port_arbiter_load_align u_load_align (
        .word     (word_q),
        .addr     (off_q),
        .funct3   (funct3_q),
        .data     (al_data),
        .misalign (al_misalign)
    );

    assign if_rvalid  = valid_q && (owner_q == REQ_IF);
    assign d_rvalid   = valid_q && (owner_q == REQ_D);
    assign if_rdata   = if_rvalid ? word_q : 32'b0;
    assign d_rdata    = d_rvalid ? al_data : 32'b0;
    assign d_misalign = d_rvalid & al_misalign;

    // Address bits above the ROM index are deliberately dropped
    logic unused_addr;
    assign unused_addr = ^{if_addr[31:IDX_W+2], d_addr[31:IDX_W+2]};

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed cases plus randomized traffic checked
// against a cycle-level behavioural model of the arbitration rules.
module tb_rom_port_arbiter;
    import rom_port_arbiter_pkg::*;

    localparam int unsigned DEPTH    = 65;
    localparam int unsigned IDX_W    = 7;
    localparam int unsigned MAX_WAIT = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             if_req = 1'b0;
    logic [31:0]      if_addr = '0;
    logic             if_gnt, if_rvalid;
    logic [31:0]      if_rdata;
    logic             d_req = 1'b0;
    logic [31:0]      d_addr = '0;
    logic [2:0]       d_funct3 = '0;
    logic             d_gnt, d_rvalid, d_misalign;
    logic [31:0]      d_rdata;
    logic [IDX_W-1:0] mem_idx;
    logic [31:0]      mem_rdata;

    logic [31:0] rom [0:127];
    assign mem_rdata = rom[mem_idx];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rom_port_arbiter #(
        .DEPTH    (DEPTH),
        .IDX_W    (IDX_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_addr     (d_addr),
        .d_funct3   (d_funct3),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_misalign (d_misalign),
        .mem_idx    (mem_idx),
        .mem_rdata  (mem_rdata)
    );

    // Reference load extraction using plain arithmetic; returns {misalign, data}
    function automatic logic [32:0] exp_load(input logic [31:0] w, input int off,
                                             input logic [2:0] f3);
        int unsigned v;
        int b, h;
        v = w >> (8 * off);
        b = int'(v % 256);
        h = int'(v % 65536);
        case (f3)
            3'b000: return {1'b0, 32'(b >= 128 ? b - 256 : b)};
            3'b100: return {1'b0, 32'(b)};
            3'b001: return (off % 2 != 0) ? {1'b1, 32'b0}
                                          : {1'b0, 32'(h >= 32768 ? h - 65536 : h)};
            3'b101: return (off % 2 != 0) ? {1'b1, 32'b0} : {1'b0, 32'(h)};
            default: return (off != 0) ? {1'b1, 32'b0} : {1'b0, w};
        endcase
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        int idx;
        idx = int'((addr >> 2) % 128);
        return (idx >= int'(DEPTH)) ? 32'b0 : rom[idx];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, d_misalign} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {if_gnt, d_gnt, if_rvalid, d_rvalid, d_misalign});
        end
        n_checks++;
        if ({if_rdata, d_rdata} !== 64'b0 || mem_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got if=%h d=%h idx=%0d expected 0", if_rdata, d_rdata,
                     mem_idx);
        end
    endtask

    task automatic test_if_fetch();
        logic [31:0] addrs [2];
        addrs[0] = 32'h04;
        addrs[1] = 32'h07;
        for (int i = 0; i < 2; i++) begin
            step();
            if_req  = 1'b1;
            if_addr = addrs[i];
            @(negedge clk);
            n_checks++;
            if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_idx !== 7'd1) begin
                n_fail++;
                $display("FAIL if_grant: got gnt=%b/%b idx=%0d expected 1/0 idx=1", if_gnt,
                         d_gnt, mem_idx);
            end
            step();
            if_req = 1'b0;
            @(negedge clk);
            n_checks++;
            if (if_rvalid !== 1'b1 || if_rdata !== 32'h00123237 || d_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL if_resp: got rvalid=%b data=%h expected 1 00123237", if_rvalid,
                         if_rdata);
            end
        end
    endtask

    task automatic test_loads();
        logic [31:0] a   [8];
        logic [2:0]  f   [8];
        logic [31:0] exd [8];
        logic        exm [8];
        a[0] = 32'h43;  f[0] = LB;  exd[0] = 32'hFFFFFF80; exm[0] = 1'b0;
        a[1] = 32'h43;  f[1] = LBU; exd[1] = 32'h00000080; exm[1] = 1'b0;
        a[2] = 32'h42;  f[2] = LH;  exd[2] = 32'hFFFF8091; exm[2] = 1'b0;
        a[3] = 32'h42;  f[3] = LHU; exd[3] = 32'h00008091; exm[3] = 1'b0;
        a[4] = 32'h42;  f[4] = LW;  exd[4] = 32'h0;        exm[4] = 1'b1;
        a[5] = 32'h41;  f[5] = LH;  exd[5] = 32'h0;        exm[5] = 1'b1;
        a[6] = 32'h40;  f[6] = LW;  exd[6] = 32'h80912213; exm[6] = 1'b0;
        a[7] = 32'h104; f[7] = LW;  exd[7] = 32'h0;        exm[7] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            d_req    = 1'b1;
            d_addr   = a[i];
            d_funct3 = f[i];
            @(negedge clk);
            n_checks++;
            if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL load_grant[%0d]: got d_gnt=%b if_gnt=%b expected 1/0", i, d_gnt,
                         if_gnt);
            end
            step();
            d_req = 1'b0;
            @(negedge clk);
            n_checks++;
            if (d_rvalid !== 1'b1 || d_rdata !== exd[i] || d_misalign !== exm[i]) begin
                n_fail++;
                $display("FAIL load_resp[%0d]: got v=%b data=%h mis=%b expected 1 %h %b", i,
                         d_rvalid, d_rdata, d_misalign, exd[i], exm[i]);
            end
        end
    endtask

    task automatic test_contention();
        logic exp_d, prev_d;
        step();
        if_req  = 1'b1;
        if_addr = 32'h04;
        step();
        d_req    = 1'b1;
        d_addr   = 32'h40;
        d_funct3 = LW;
        prev_d   = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (prev_d ? (d_rvalid !== 1'b1 || d_rdata !== 32'h80912213 || if_rvalid !== 1'b0)
                       : (if_rvalid !== 1'b1 || if_rdata !== 32'h00123237 || d_rvalid !== 1'b0))
            begin
                n_fail++;
                $display("FAIL contention_resp[%0d]: got if_v=%b d_v=%b expected d=%b", k,
                         if_rvalid, d_rvalid, prev_d);
            end
            if (k == 8) break;
`ifdef ARB_RR_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = (k % 4 != 3);
`endif
            n_checks++;
            if (d_gnt !== exp_d || if_gnt !== !exp_d) begin
                n_fail++;
                $display("FAIL contention_grant[%0d]: got d=%b if=%b expected d=%b", k, d_gnt,
                         if_gnt, exp_d);
            end
            prev_d = exp_d;
            step();
            if (k == 7) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        step();
        d_req    = 1'b1;
        d_addr   = 32'h40;
        d_funct3 = LW;
        if_req   = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, d_misalign} !== 5'b0 || mem_idx !== '0 ||
            d_rdata !== 32'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b idx=%0d d=%h expected all 0",
                     {if_gnt, d_gnt, if_rvalid, d_rvalid, d_misalign}, mem_idx, d_rdata);
        end
        step();
        if_req = 1'b0;
        d_req  = 1'b0;
        rst    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_rvalid: got if=%b d=%b expected 0/0", if_rvalid,
                         d_rvalid);
            end
        end
        step();
    endtask

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        logic        mis;
    } resp_t;

    function automatic logic [31:0] rand_addr();
        return ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 300));
    endfunction

    task automatic test_random();
        resp_t   q[$];
        resp_t   r, e;
        int      denied;
        req_id_e last;
        logic    eg_if, eg_d, if_hold, d_hold;
        logic [32:0] ld;
        logic [IDX_W-1:0] exp_idx;
        denied  = 0;
        last    = REQ_IF;
        if_hold = 1'b0;
        d_hold  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!if_hold) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = rand_addr();
            end
            if (!d_hold) begin
                d_req    = ($urandom_range(0, 3) != 0);
                d_addr   = rand_addr();
                d_funct3 = 3'($urandom);
            end
            @(negedge clk);
            eg_if = 1'b0;
            eg_d  = 1'b0;
            if (if_req && d_req) begin
`ifdef ARB_RR_EN
                if (last == REQ_D) eg_if = 1'b1;
                else eg_d = 1'b1;
`else
                if (denied >= int'(MAX_WAIT)) eg_if = 1'b1;
                else eg_d = 1'b1;
`endif
            end else begin
                eg_if = if_req;
                eg_d  = d_req;
            end
            exp_idx = eg_d ? IDX_W'((d_addr >> 2) % 128)
                           : (eg_if ? IDX_W'((if_addr >> 2) % 128) : '0);
            n_checks++;
            if (if_gnt !== eg_if || d_gnt !== eg_d || mem_idx !== exp_idx) begin
                n_fail++;
                $display("FAIL rand_grant[%0d]: got if=%b d=%b idx=%0d expected %b %b %0d", c,
                         if_gnt, d_gnt, mem_idx, eg_if, eg_d, exp_idx);
            end
            n_checks++;
            if (q.size() == 0) begin
                if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_idle[%0d]: got if_v=%b d_v=%b expected 0/0", c,
                             if_rvalid, d_rvalid);
                end
            end else begin
                e = q.pop_front();
                if (e.is_d ? (d_rvalid !== 1'b1 || if_rvalid !== 1'b0 || d_rdata !== e.data ||
                              d_misalign !== e.mis)
                           : (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_rdata !== e.data))
                begin
                    n_fail++;
                    $display("FAIL rand_resp[%0d]: got if=%b/%h d=%b/%h/%b expected d=%b %h %b",
                             c, if_rvalid, if_rdata, d_rvalid, d_rdata, d_misalign, e.is_d,
                             e.data, e.mis);
                end
            end
            if (eg_d) begin
                ld     = exp_load(rom_word(d_addr), int'(d_addr % 4), d_funct3);
                r.is_d = 1'b1;
                r.data = ld[31:0];
                r.mis  = ld[32];
                q.push_back(r);
                last = REQ_D;
            end else if (eg_if) begin
                r.is_d = 1'b0;
                r.data = rom_word(if_addr);
                r.mis  = 1'b0;
                q.push_back(r);
                last = REQ_IF;
            end
            denied  = (if_req && !eg_if) ? ((denied < int'(MAX_WAIT)) ? denied + 1 : denied)
                                         : 0;
            if_hold = if_req && !eg_if;
            d_hold  = d_req && !eg_d;
            step();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = $urandom;
        rom[1]  = 32'h00123237;
        rom[16] = 32'h80912213;
        rom[65] = 32'hDEADBEEF;
        test_reset();
        test_if_fetch();
        test_loads();
        test_contention();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
